// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between a show-ahead FIFO (master) and the
// serialiser that pops it (slave).
interface fifo_uart_tx_if #(
  parameter int unsigned BITS = 32
);
  logic [BITS-1:0] fifo_dout;
  logic            fifo_pndng;
  logic            fifo_pop;

  modport master (output fifo_dout, output fifo_pndng, input fifo_pop);
  modport slave  (input fifo_dout, input fifo_pndng, output fifo_pop);
endinterface

// File: rtl/fifo_uart_tx.sv
// Serialises BITS-wide FIFO words onto an 8N1 UART line, least-significant
// byte first, popping the next word gaplessly on the last stop-bit cycle.
module fifo_uart_tx #(
  parameter int unsigned BITS         = 32,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned BYTES     = BITS / 8;
  localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned BAUD_LAST = CLKS_PER_BIT - 1;
  localparam int unsigned BYTE_LAST = (BYTES > 0) ? BYTES - 1 : 0;

  if ((BITS % 8) != 0 || BITS == 0) begin : g_bad_bits
    $error("fifo_uart_tx: BITS must be a non-zero multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [2:0]        bit_q,   bit_d;
  logic [BYTE_W-1:0] byte_q,  byte_d;
  logic [BITS-1:0]   shift_q, shift_d;
  logic              tx_q,    tx_d;

  logic       baud_tc;
  logic       last_byte;
  logic       pop_slot;
  logic       pop_c;
  logic [7:0] cur_byte;

  assign baud_tc   = (baud_q == BAUD_W'(BAUD_LAST));
  assign last_byte = (byte_q == BYTE_W'(BYTE_LAST));
  // A new word may start from IDLE or on the very last cycle of the last stop bit.
  assign pop_slot  = (state_q == IDLE) || ((state_q == STOP) && baud_tc && last_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    pop_c    = 1'b0;
    tx_d     = 1'b1;
    cur_byte = '0;

    unique case (state_q)
      IDLE: ;
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (!last_byte) begin
            byte_d  = byte_q + BYTE_W'(1);
            shift_d = shift_q >> 8;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop overrides the end-of-word transition; gated by rst_n so no pop escapes during reset.
    if (pop_slot && enable && bus.fifo_pndng && rst_n) begin
      pop_c   = 1'b1;
      shift_d = bus.fifo_dout;
      byte_d  = '0;
      bit_d   = '0;
      baud_d  = '0;
      state_d = START;
    end

    // tx is computed from next state so the flop presents the bit on the cycle it belongs to.
    cur_byte = shift_d[7:0];
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.fifo_pop = pop_c;
  assign busy         = (state_q != IDLE) || pop_c;
  assign tx           = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-backed FIFO feeds the DUT and a
// waveform-level reference model predicts every tx, busy and pop cycle.
module tb_fifo_uart_tx;

  localparam int unsigned BITS = 32;
  localparam int unsigned CPB  = 4;
  localparam int unsigned WORD_CYC = (BITS / 8) * 10 * CPB;

  logic clk;
  logic rst_n;
  logic enable;
  logic tx;
  logic busy;

  fifo_uart_tx_if #(.BITS(BITS)) bus ();

  fifo_uart_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus),
    .tx     (tx),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [BITS-1:0] fq[$];   // upstream FIFO contents
  bit              exp_q[$]; // expected tx level for each coming cycle
  bit last_tx, last_busy, last_pop;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive_fifo();
    bus.fifo_pndng = (fq.size() > 0);
    bus.fifo_dout  = (fq.size() > 0) ? fq[0] : BITS'($urandom());
  endtask

  // Expected serial waveform of one word: per byte a start bit, 8 data bits LSB first, a stop bit.
  task automatic push_frame(input logic [BITS-1:0] w);
    for (int b = 0; b < BITS / 8; b++) begin
      logic [7:0] by;
      by = 8'((w >> (8 * b)) & 'hFF);
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(by[i]);
      repeat (CPB) exp_q.push_back(1'b1);
    end
  endtask

  // One clock: sample at negedge against the model, advance the FIFO after the posedge.
  task automatic step();
    bit exp_pop, exp_tx, exp_busy, dut_pop;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_pop = 1'b0; exp_tx = 1'b1; exp_busy = 1'b0;
    end else begin
      exp_pop  = (exp_q.size() <= 1) && enable && bus.fifo_pndng;
      exp_tx   = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
      exp_busy = (exp_q.size() > 0) || exp_pop;
    end
    total++;
    if (tx !== exp_tx) begin
      bad++; $display("FAIL tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx);
    end
    total++;
    if (busy !== exp_busy) begin
      bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
    end
    total++;
    if (bus.fifo_pop !== exp_pop) begin
      bad++; $display("FAIL pop cyc=%0d got=%b exp=%b", cyc, bus.fifo_pop, exp_pop);
    end
    total++;
    if (bus.fifo_pop === 1'b1 && bus.fifo_pndng !== 1'b1) begin
      bad++; $display("FAIL pop_empty cyc=%0d got pop=1 exp pop=0 (pndng=0)", cyc);
    end
    last_tx = tx; last_busy = busy; last_pop = (bus.fifo_pop === 1'b1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_pop) push_frame(bus.fifo_dout);
    dut_pop = (bus.fifo_pop === 1'b1);
    @(posedge clk);
    #1;
    if (dut_pop && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    fq.push_back(BITS'($urandom()));
    drive_fifo();
    repeat (3) step();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_pop !== 1'b0) begin
      bad++; $display("FAIL reset_state got tx=%b busy=%b pop=%b exp 1/0/0", tx, busy, bus.fifo_pop);
    end
    fq.delete(); enable = 1'b0; drive_fifo();
    rst_n = 1'b1;
    repeat (5) step();
    total++;
    if (last_tx !== 1'b1 || last_busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle got tx=%b busy=%b exp 1/0", last_tx, last_busy);
    end
  endtask

  task automatic test_single_word();
    logic [BITS-1:0] w;
    bit log_tx[$];
    int pops, busy_cnt, p;
    w = 32'hA53C0F81;
    pops = 0; busy_cnt = 0; p = -1;
    fq.push_back(w); drive_fifo(); enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      log_tx.push_back(last_tx);
      if (last_pop) begin pops++; if (p < 0) p = k; end
      if (last_busy) busy_cnt++;
    end
    total++;
    if (pops != 1) begin bad++; $display("FAIL single_pops got=%0d exp=1", pops); end
    total++;
    if (busy_cnt != WORD_CYC + 1) begin
      bad++; $display("FAIL single_busy got=%0d exp=%0d", busy_cnt, WORD_CYC + 1);
    end
    if (p >= 0) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] got, exp_b;
        int base;
        base = p + 1 + b * 10 * CPB + CPB / 2;
        exp_b = 8'((w >> (8 * b)) & 'hFF);
        for (int i = 0; i < 8; i++) got[i] = log_tx[base + (i + 1) * CPB];
        total++;
        if (got !== exp_b || log_tx[base] !== 1'b0 || log_tx[base + 9 * CPB] !== 1'b1) begin
          bad++; $display("FAIL single_byte%0d got=%h start=%b stop=%b exp=%h start=0 stop=1",
                          b, got, log_tx[base], log_tx[base + 9 * CPB], exp_b);
        end
      end
    end
    total++;
    if (last_tx !== 1'b1 || last_busy !== 1'b0) begin
      bad++; $display("FAIL single_end got tx=%b busy=%b exp 1/0", last_tx, last_busy);
    end
  endtask

  task automatic test_back_to_back();
    int pop_at[$];
    bit log_busy[$];
    int busy_cnt;
    busy_cnt = 0;
    fq.push_back(32'h00000000); fq.push_back(32'hFFFFFFFF); drive_fifo(); enable = 1'b1;
    for (int k = 0; k < 400; k++) begin
      step();
      log_busy.push_back(last_busy);
      if (last_pop) pop_at.push_back(k);
      if (last_busy) busy_cnt++;
    end
    total++;
    if (pop_at.size() != 2) begin
      bad++; $display("FAIL b2b_pops got=%0d exp=2", pop_at.size());
    end else begin
      total++;
      if (pop_at[1] - pop_at[0] != WORD_CYC) begin
        bad++; $display("FAIL b2b_gap got=%0d exp=%0d", pop_at[1] - pop_at[0], WORD_CYC);
      end
      for (int k = pop_at[0]; k <= pop_at[0] + 2 * WORD_CYC; k++) begin
        if (!log_busy[k]) begin
          total++; bad++;
          $display("FAIL b2b_busy_gap at=%0d got=0 exp=1", k);
          break;
        end
      end
    end
    total++;
    if (busy_cnt != 2 * WORD_CYC + 1) begin
      bad++; $display("FAIL b2b_busy got=%0d exp=%0d", busy_cnt, 2 * WORD_CYC + 1);
    end
  endtask

  task automatic test_empty();
    int viol;
    viol = 0;
    fq.delete(); drive_fifo(); enable = 1'b1;
    repeat (100) begin
      step();
      if (last_pop || !last_tx || last_busy) viol++;
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL empty_idle got=%0d bad cycles exp=0", viol); end
  endtask

  task automatic test_enable_drop();
    int pops, busy_cnt;
    pops = 0; busy_cnt = 0;
    fq.push_back(BITS'($urandom())); fq.push_back(BITS'($urandom())); drive_fifo(); enable = 1'b1;
    for (int k = 0; k < 220; k++) begin
      if (k == 20) enable = 1'b0;
      step();
      if (last_pop) pops++;
      if (last_busy) busy_cnt++;
    end
    total++;
    if (pops != 1) begin bad++; $display("FAIL endrop_pops got=%0d exp=1", pops); end
    total++;
    if (busy_cnt != WORD_CYC + 1) begin
      bad++; $display("FAIL endrop_busy got=%0d exp=%0d", busy_cnt, WORD_CYC + 1);
    end
    total++;
    if (fq.size() != 1) begin bad++; $display("FAIL endrop_left got=%0d exp=1", fq.size()); end
    fq.delete(); drive_fifo(); enable = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    logic [BITS-1:0] w1;
    bit log_tx[$];
    int pops, p;
    w1 = BITS'($urandom());
    fq.push_back(BITS'($urandom())); fq.push_back(w1); drive_fifo(); enable = 1'b1;
    // pop cycle, two full bytes, byte-2 start bit, then into its data bits
    repeat (1 + 1 + 20 * CPB + CPB + 6) step();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_pop !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got tx=%b busy=%b pop=%b exp 1/0/0", tx, busy, bus.fifo_pop);
    end
    repeat (2) step();
    rst_n = 1'b1;
    pops = 0; p = -1;
    for (int k = 0; k < 180; k++) begin
      step();
      log_tx.push_back(last_tx);
      if (last_pop) begin pops++; if (p < 0) p = k; end
    end
    total++;
    if (pops != 1 || p != 0) begin
      bad++; $display("FAIL rstmid_repop got pops=%0d first=%0d exp pops=1 first=0", pops, p);
    end else begin
      logic [7:0] got;
      for (int i = 0; i < 8; i++) got[i] = log_tx[1 + CPB / 2 + (i + 1) * CPB];
      total++;
      if (got !== w1[7:0]) begin
        bad++; $display("FAIL rstmid_byte0 got=%h exp=%h", got, w1[7:0]);
      end
    end
  endtask

  task automatic test_random();
    int pops;
    pops = 0;
    enable = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0 && fq.size() < 4) begin
        fq.push_back(BITS'($urandom()));
        drive_fifo();
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step();
      if (last_pop) pops++;
    end
    enable = 1'b1;
    for (int k = 0; k < 2000 && (fq.size() > 0 || exp_q.size() > 0); k++) step();
    repeat (2) step();
    total++;
    if (fq.size() != 0 || last_busy !== 1'b0 || last_tx !== 1'b1) begin
      bad++; $display("FAIL random_drain got left=%0d busy=%b tx=%b exp 0/0/1", fq.size(), last_busy, last_tx);
    end
    total++;
    if (pops == 0) begin bad++; $display("FAIL random_activity got pops=0 exp >0"); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    drive_fifo();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
